// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: state encoding, instruction codes and the
// 1149.1 next-state function used by the TAP controller.
package jtag_pkg;

    // Standard 1149.1 state encoding (TLR = 4'hF).
    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PA_DR  = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PA_IR  = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } tap_state_e;

    // Instruction codes; BYPASS is all ones at any IR width.
    localparam int IR_BYPASS = -1;
    localparam int IR_IDCODE = 1;
    localparam int IR_USER   = 2;

    function automatic tap_state_e next_tap_state(
        input tap_state_e s,
        input logic       tms
    );
        tap_state_e n;
        n = TLR;
        case (s)
            TLR:     n = tms ? TLR    : RTI;
            RTI:     n = tms ? SEL_DR : RTI;
            SEL_DR:  n = tms ? SEL_IR : CAP_DR;
            CAP_DR:  n = tms ? EX1_DR : SH_DR;
            SH_DR:   n = tms ? EX1_DR : SH_DR;
            EX1_DR:  n = tms ? UPD_DR : PA_DR;
            PA_DR:   n = tms ? EX2_DR : PA_DR;
            EX2_DR:  n = tms ? UPD_DR : SH_DR;
            UPD_DR:  n = tms ? SEL_DR : RTI;
            SEL_IR:  n = tms ? TLR    : CAP_IR;
            CAP_IR:  n = tms ? EX1_IR : SH_IR;
            SH_IR:   n = tms ? EX1_IR : SH_IR;
            EX1_IR:  n = tms ? UPD_IR : PA_IR;
            PA_IR:   n = tms ? EX2_IR : PA_IR;
            EX2_IR:  n = tms ? UPD_IR : SH_IR;
            UPD_IR:  n = tms ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_slave_fsm.sv
// TAP controller state register.
// Ports: tck, trst (sync, active-high), tms in; tap_state out.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_e tap_state
);

    tap_state_e r_state;

    always_ff @(posedge tck) begin
        if (trst) begin
            r_state <= TLR;
        end else begin
            r_state <= next_tap_state(r_state, tms);
        end
    end

    assign tap_state = r_state;

endmodule

// File: rtl/jtag_tap_slave.sv
// JTAG target TAP with IR, BYPASS, IDCODE and a USER data register.
// Ports: tck/trst/tms/tdi in, tdo/tdo_en out, tap_state, USER capture/update.
module jtag_tap_slave
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5679,
    parameter int          USER_WIDTH = 8
) (
    input  logic                  tck,
    input  logic                  trst,
    input  logic                  tms,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic [3:0]            tap_state,
    input  logic [USER_WIDTH-1:0] user_capture_d,
    output logic [USER_WIDTH-1:0] user_dr_q,
    output logic                  user_update
);

    tap_state_e            w_state;
    logic [IR_WIDTH-1:0]   r_ir;
    logic [IR_WIDTH-1:0]   r_ir_sr;
    logic                  r_bypass;
    logic [31:0]           r_id_sr;
    logic [USER_WIDTH-1:0] r_user_sr;
    logic [USER_WIDTH-1:0] r_user_dr_q;
    logic                  r_user_update;
    logic                  r_tdo;
    logic                  r_tdo_en;
    logic                  w_sel_id;
    logic                  w_sel_user;
    logic                  w_dr_lsb;

    jtag_tap_fsm u_fsm (
        .tck       (tck),
        .trst      (trst),
        .tms       (tms),
        .tap_state (w_state)
    );

    // Unknown codes (including 0) fall through to BYPASS.
    assign w_sel_id   = (r_ir == IR_WIDTH'(IR_IDCODE));
    assign w_sel_user = (r_ir == IR_WIDTH'(IR_USER));
    assign w_dr_lsb   = w_sel_id   ? r_id_sr[0]   :
                        w_sel_user ? r_user_sr[0] : r_bypass;

    always_ff @(posedge tck) begin
        if (trst) begin
            r_ir    <= IR_WIDTH'(IR_IDCODE);
            r_ir_sr <= '0;
        end else begin
            case (w_state)
                TLR:     r_ir    <= IR_WIDTH'(IR_IDCODE);
                CAP_IR:  r_ir_sr <= IR_WIDTH'(1);
                SH_IR:   r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
                UPD_IR:  r_ir    <= r_ir_sr;
                default: ;
            endcase
        end
    end

    always_ff @(posedge tck) begin
        if (trst) begin
            r_bypass      <= 1'b0;
            r_id_sr       <= '0;
            r_user_sr     <= '0;
            r_user_dr_q   <= '0;
            r_user_update <= 1'b0;
        end else begin
            r_user_update <= 1'b0;
            case (w_state)
                CAP_DR: begin
                    if (w_sel_id)        r_id_sr   <= IDCODE_VAL;
                    else if (w_sel_user) r_user_sr <= user_capture_d;
                    else                 r_bypass  <= 1'b0;
                end
                SH_DR: begin
                    // Shift right with tdi into the MSB; the concat/shift
                    // form also covers a one-bit USER register.
                    if (w_sel_id)
                        r_id_sr <= {tdi, r_id_sr[31:1]};
                    else if (w_sel_user)
                        r_user_sr <= USER_WIDTH'({tdi, r_user_sr} >> 1);
                    else
                        r_bypass <= tdi;
                end
                UPD_DR: begin
                    if (w_sel_user) begin
                        r_user_dr_q   <= r_user_sr;
                        r_user_update <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // TDO launches on the falling edge so the captured LSB is valid
    // before the first shifting rising edge.
    always_ff @(negedge tck) begin
        if (trst) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            case (w_state)
                SH_IR: begin
                    r_tdo    <= r_ir_sr[0];
                    r_tdo_en <= 1'b1;
                end
                SH_DR: begin
                    r_tdo    <= w_dr_lsb;
                    r_tdo_en <= 1'b1;
                end
                default: begin
                    r_tdo    <= 1'b0;
                    r_tdo_en <= 1'b0;
                end
            endcase
        end
    end

    assign tdo         = r_tdo;
    assign tdo_en      = r_tdo_en;
    assign tap_state   = w_state;
    assign user_dr_q   = r_user_dr_q;
    assign user_update = r_user_update;

endmodule
